// File: rtl/ir_fetch_queue.sv
// ir_fetch_queue: instruction register fronted by a DEPTH-entry prefetch FIFO.
// Fetched words are queued as they are acknowledged. A load strobe moves the
// head word into the held instruction register, and the decoded fields are
// driven from that register. A flush empties the queue and invalidates the IR.
module ir_fetch_queue #(
    parameter int INST_W = 18,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       ack_i,
    input  logic [INST_W-1:0]          inst_i,
    output logic                       ready_o,
    input  logic                       ir_load_i,
    input  logic                       flush_i,
    output logic                       ir_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       ovf_o,
    output logic [2:0]                 op_o,
    output logic [2:0]                 func_o,
    output logic [2:0]                 rs_o,
    output logic [2:0]                 rs2_o,
    output logic [2:0]                 rd_o,
    output logic [2:0]                 count_o,
    output logic [7:0]                 immed_o,
    output logic [7:0]                 offset_o,
    output logic [7:0]                 disp_o,
    output logic [ADDR_W-1:0]          addr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    // Queue storage and state
    logic [INST_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              ready_r;
    logic              ovf_r;
    logic [INST_W-1:0] ir_r;
    logic              ir_valid_r;

    // Next-state values
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic [PTR_W-1:0]  wr_ptr_next_s;
    logic [PTR_W-1:0]  rd_ptr_next_s;
    logic [LVL_W-1:0]  level_next_s;
    logic              ovf_next_s;
    logic [INST_W-1:0] ir_next_s;
    logic              ir_valid_next_s;

    // Transfer qualification and next-state computation; flush overrides all.
    always_comb begin
        pop_s           = 1'b0;
        push_s          = 1'b0;
        drop_s          = 1'b0;
        wr_ptr_next_s   = wr_ptr_r;
        rd_ptr_next_s   = rd_ptr_r;
        level_next_s    = level_r;
        ovf_next_s      = ovf_r;
        ir_next_s       = ir_r;
        ir_valid_next_s = ir_valid_r;

        if (flush_i) begin
            // The IR keeps its contents; only the valid flag is cleared.
            wr_ptr_next_s   = {PTR_W{1'b0}};
            rd_ptr_next_s   = {PTR_W{1'b0}};
            level_next_s    = {LVL_W{1'b0}};
            ovf_next_s      = 1'b0;
            ir_valid_next_s = 1'b0;
        end else begin
            pop_s  = ir_load_i && (level_r != {LVL_W{1'b0}});
            // A full queue still accepts a word when the head leaves this cycle.
            push_s = ack_i && ((level_r != LVL_FULL) || pop_s);
            drop_s = ack_i && (level_r == LVL_FULL) && !pop_s;

            if (push_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end

            if (pop_s) begin
                // The IR always takes the old head, never the incoming word.
                rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
                ir_next_s     = mem_r[rd_ptr_r];
            end else begin
                rd_ptr_next_s = rd_ptr_r;
                ir_next_s     = ir_r;
            end

            if (ir_load_i) begin
                // A load from an empty queue invalidates the IR but holds its bits.
                ir_valid_next_s = pop_s;
            end else begin
                ir_valid_next_s = ir_valid_r;
            end

            case ({push_s, pop_s})
                2'b10:   level_next_s = level_r + LVL_W'(1);
                2'b01:   level_next_s = level_r - LVL_W'(1);
                default: level_next_s = level_r;
            endcase

            if (drop_s) begin
                ovf_next_s = 1'b1;
            end else begin
                ovf_next_s = ovf_r;
            end
        end
    end

    // Control state registers; ready is registered from the next level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {LVL_W{1'b0}};
            ready_r    <= 1'b1;
            ovf_r      <= 1'b0;
            ir_r       <= {INST_W{1'b0}};
            ir_valid_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            level_r    <= level_next_s;
            ready_r    <= (level_next_s != LVL_FULL);
            ovf_r      <= ovf_next_s;
            ir_r       <= ir_next_s;
            ir_valid_r <= ir_valid_next_s;
        end
    end

    // Queue storage: write the accepted word at the write pointer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {INST_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= inst_i;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Status outputs come straight from registers.
    assign ready_o    = ready_r;
    assign level_o    = level_r;
    assign ovf_o      = ovf_r;
    assign ir_valid_o = ir_valid_r;

    // Field decode from the held IR; func moves to the low bits when op MSB is set.
    always_comb begin
        op_o  = ir_r[INST_W-1:INST_W-3];
        rd_o  = ir_r[INST_W-5:INST_W-7];
        rs_o  = ir_r[INST_W-8:INST_W-10];
        rs2_o = ir_r[7:5];
        count_o  = ir_r[7:5];
        immed_o  = ir_r[7:0];
        offset_o = ir_r[7:0];
        disp_o   = ir_r[7:0];
        addr_o   = ir_r[ADDR_W-1:0];
        if (ir_r[INST_W-1]) begin
            func_o = ir_r[2:0];
        end else begin
            func_o = ir_r[INST_W-2:INST_W-4];
        end
    end

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Directed self-checking bench for ir_fetch_queue (INST_W=18, DEPTH=4, ADDR_W=12).
module tb_ir_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        ack;
    logic [17:0] inst;
    logic        ready;
    logic        ir_load;
    logic        flush;
    logic        ir_valid;
    logic [2:0]  level;
    logic        ovf;
    logic [2:0]  op, func, rs, rs2, rd, count;
    logic [7:0]  immed, offset, disp;
    logic [11:0] addr;

    int n_cmp  = 0;
    int n_fail = 0;

    ir_fetch_queue #(.INST_W(18), .DEPTH(4), .ADDR_W(12)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ack_i(ack), .inst_i(inst),
        .ready_o(ready), .ir_load_i(ir_load), .flush_i(flush),
        .ir_valid_o(ir_valid), .level_o(level), .ovf_o(ovf),
        .op_o(op), .func_o(func), .rs_o(rs), .rs2_o(rs2), .rd_o(rd),
        .count_o(count), .immed_o(immed), .offset_o(offset), .disp_o(disp),
        .addr_o(addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge.
    task automatic cyc(input logic a, input logic [17:0] w, input logic l, input logic f);
        ack = a; inst = w; ir_load = l; flush = f;
        @(posedge clk);
        #1;
        ack = 1'b0; ir_load = 1'b0; flush = 1'b0; inst = 18'h0;
    endtask

    logic [17:0] w_tab [5];

    initial begin
        rst_n = 1'b0; ack = 1'b0; inst = 18'h0; ir_load = 1'b0; flush = 1'b0;
        w_tab[0] = 18'h00111; w_tab[1] = 18'h00222; w_tab[2] = 18'h00333;
        w_tab[3] = 18'h00444; w_tab[4] = 18'h00555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_ovf",   32'(ovf), 32'd0);
        chk("rst_op",    32'(op), 32'd0);
        chk("rst_immed", 32'(immed), 32'd0);
        chk("rst_addr",  32'(addr), 32'd0);
        rst_n = 1'b1;

        // Field decode
        cyc(1'b1, 18'h0B8F3, 1'b0, 1'b0);
        chk("dec_level1", 32'(level), 32'd1);
        chk("dec_valid0", 32'(ir_valid), 32'd0);
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("dec_level0", 32'(level), 32'd0);
        chk("dec_valid",  32'(ir_valid), 32'd1);
        chk("dec_op",     32'(op), 32'd1);
        chk("dec_func",   32'(func), 32'd2);
        chk("dec_rd",     32'(rd), 32'd7);
        chk("dec_rs",     32'(rs), 32'd0);
        chk("dec_rs2",    32'(rs2), 32'd7);
        chk("dec_count",  32'(count), 32'd7);
        chk("dec_immed",  32'(immed), 32'hF3);
        chk("dec_offset", 32'(offset), 32'hF3);
        chk("dec_disp",   32'(disp), 32'hF3);
        chk("dec_addr",   32'(addr), 32'h8F3);

        // Function field with op MSB set
        cyc(1'b1, 18'h38005, 1'b0, 1'b0);
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("msb_op",   32'(op), 32'd7);
        chk("msb_func", 32'(func), 32'd5);

        // Fill, overflow and flush
        for (int i = 0; i < 4; i++) cyc(1'b1, 18'h10001 + 18'(i), 1'b0, 1'b0);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_ready", 32'(ready), 32'd0);
        chk("fill_ovf0",  32'(ovf), 32'd0);
        cyc(1'b1, 18'h10005, 1'b0, 1'b0);
        chk("drop_level", 32'(level), 32'd4);
        chk("drop_ovf",   32'(ovf), 32'd1);
        cyc(1'b0, 18'h0, 1'b0, 1'b1);
        chk("fl_level", 32'(level), 32'd0);
        chk("fl_ovf",   32'(ovf), 32'd0);
        chk("fl_ready", 32'(ready), 32'd1);
        chk("fl_valid", 32'(ir_valid), 32'd0);
        chk("fl_ir_hold", 32'(func), 32'd5);

        // Full plus simultaneous push and pop
        for (int i = 0; i < 4; i++) cyc(1'b1, w_tab[i], 1'b0, 1'b0);
        chk("full_level", 32'(level), 32'd4);
        cyc(1'b1, w_tab[4], 1'b1, 1'b0);
        chk("fpp_level", 32'(level), 32'd4);
        chk("fpp_addr",  32'(addr), 32'h111);
        chk("fpp_ovf",   32'(ovf), 32'd0);
        chk("fpp_ready", 32'(ready), 32'd0);
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("ord_addr1", 32'(addr), 32'h222);
        chk("ord_lvl1",  32'(level), 32'd3);
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("ord_addr2", 32'(addr), 32'h333);
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("ord_addr3", 32'(addr), 32'h444);
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("ord_addr4", 32'(addr), 32'h555);
        chk("ord_lvl4",  32'(level), 32'd0);

        // Empty load
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("empty_valid", 32'(ir_valid), 32'd0);
        chk("empty_addr",  32'(addr), 32'h555);
        chk("empty_level", 32'(level), 32'd0);

        // Level-1 push and pop
        cyc(1'b1, 18'h00AAA, 1'b0, 1'b0);
        cyc(1'b1, 18'h00BBB, 1'b1, 1'b0);
        chk("l1_addr",  32'(addr), 32'hAAA);
        chk("l1_level", 32'(level), 32'd1);
        chk("l1_valid", 32'(ir_valid), 32'd1);
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("l1_addr2",  32'(addr), 32'hBBB);
        chk("l1_level2", 32'(level), 32'd0);

        // Flush priority over ack and load
        cyc(1'b1, 18'h00CCC, 1'b0, 1'b0);
        cyc(1'b1, 18'h00DDD, 1'b1, 1'b1);
        chk("fp_level", 32'(level), 32'd0);
        chk("fp_valid", 32'(ir_valid), 32'd0);
        chk("fp_addr",  32'(addr), 32'hBBB);
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("fp_after_valid", 32'(ir_valid), 32'd0);
        chk("fp_after_addr",  32'(addr), 32'hBBB);

        // Asynchronous reset mid-cycle
        cyc(1'b1, 18'h3FFFF, 1'b0, 1'b0);
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("pre_op", 32'(op), 32'd7);
        for (int i = 0; i < 5; i++) cyc(1'b1, 18'h01000 + 18'(i), 1'b0, 1'b0);
        chk("pre_ovf",   32'(ovf), 32'd1);
        chk("pre_level", 32'(level), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_level", 32'(level), 32'd0);
        chk("ar_ready", 32'(ready), 32'd1);
        chk("ar_valid", 32'(ir_valid), 32'd0);
        chk("ar_ovf",   32'(ovf), 32'd0);
        chk("ar_op",    32'(op), 32'd0);
        chk("ar_addr",  32'(addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 18'h0, 1'b1, 1'b0);
        chk("post_rst_valid", 32'(ir_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_fetch_queue.md
# ir_fetch_queue

Parametrised instruction register with an in-front prefetch queue, sitting between the instruction-memory fetch port and the control unit of the Gumnut core. Fetched words are buffered in a DEPTH-entry FIFO as they are acknowledged. On a load strobe from the control unit, the head word is transferred into a held instruction register. Decoded fields (opcode, function, register selects, immediate, address) are driven from that register. A flush discards all prefetched words on branches, jumps and interrupts.

## Interface
- INST_W, 18, instruction width; must be >= 18.
- DEPTH, 4, queue entries; power of two, >= 2.
- ADDR_W, 12, address-field width; must be <= INST_W-6.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- ack_i  in  1  fetch word valid on inst_i this cycle.
- inst_i  in  INST_W  fetched instruction word.
- ready_o  out  1  queue can accept a word (level_o < DEPTH).
- ir_load_i  in  1  control unit requests the next instruction into the IR.
- flush_i  in  1  discard queue contents and invalidate the IR.
- ir_valid_o  out  1  the IR holds an instruction loaded since the last flush or empty load.
- level_o  out  $clog2(DEPTH+1)  number of queued words.
- ovf_o  out  1  sticky flag: a fetched word was dropped.
- op_o, func_o, rs_o, rs2_o, rd_o, count_o  out  3 each  decoded fields.
- immed_o, offset_o, disp_o  out  8 each  low-byte fields.
- addr_o  out  ADDR_W  address field.

## Operation
- The queue is circular, with read and write pointers of width log2(DEPTH) that wrap modulo DEPTH, plus a level counter.
- **Push.** A push occurs when ack_i=1 and (level < DEPTH or a pop occurs in the same cycle). The word is written at the write pointer.
- **Drop.** If ack_i=1, level = DEPTH and there is no pop, the word is discarded and ovf_o is set. ovf_o stays set until flush or reset.
- **Pop.** A pop occurs when ir_load_i=1 and level > 0. The IR takes the head word, ir_valid_o goes to 1 and the read pointer advances.
- **Empty load.** If ir_load_i=1 and level = 0, ir_valid_o goes to 0 and the IR contents hold. There is no bypass from inst_i to the IR.
- **Simultaneous push and pop.** The level is unchanged and both pointers advance. This applies when full and when level = 1. With level = 1, the IR receives the old head, not the incoming word.
- **Flush (priority over everything).** Pointers and level go to 0, ir_valid_o to 0 and ovf_o to 0. An ack_i or ir_load_i in the same cycle is ignored. The IR contents hold.
- **Field decode.** Combinational from the IR (w = INST_W):
  - op = IR[w-1:w-3].
  - func = IR[w-1] ? IR[2:0] : IR[w-2:w-4].
  - rd = IR[w-5:w-7].
  - rs = IR[w-8:w-10].
  - rs2 = count = IR[7:5].
  - immed = offset = disp = IR[7:0].
  - addr = IR[ADDR_W-1:0].
- Bits between rs and bit 8, when INST_W > 18, are ignored.

## Timing
- **Reset.** Asynchronous assert, with release taking effect at the next rising edge. On reset:
  - IR = 0, so all field outputs are 0.
  - level_o = 0, ready_o = 1, ir_valid_o = 0, ovf_o = 0.
  - Pointers = 0.
- A reset mid-operation discards all queued words.
- Push latency is 1 cycle: a word acknowledged at edge k is counted in level_o after k and is poppable from cycle k+1.
- Load latency is 1 cycle: a pop at edge k updates the fields and ir_valid_o immediately after k.
- Minimum latency from ack_i to the decoded fields is therefore 2 edges.
- ready_o, level_o and ovf_o are registered-state functions and never depend combinationally on ack_i, ir_load_i or flush_i.
- Sustained throughput is one push and one pop per cycle.

## Test plan
- **Field decode.** Reset, ack 18'h0B8F3, load next cycle -> op=1, func=2, rd=7, rs=0, rs2=7, immed=8'hF3, addr=12'h8F3, ir_valid_o=1, level_o 1->0.
- **Function field for op MSB set.** Push and load 18'h38005 -> op=7, func=5 (taken from IR[2:0]).
- **Fill, overflow and flush.** Push 5 words with DEPTH=4 and no load -> level_o=4, ready_o=0, 5th word dropped, ovf_o=1. Flush -> level_o=0, ovf_o=0, ready_o=1, ir_valid_o=0.
- **Full plus push and pop.** At level=4, ack and load in the same cycle -> level_o stays 4, IR = oldest word, the new word lands last. Confirm order with 4 subsequent loads.
- **Empty load, level-1 push and pop.**
  - Load with level=0 -> ir_valid_o=0, fields unchanged.
  - At level=1, ack W2 with load -> IR=W1, level_o=1.
  - Next load -> IR=W2.
- **Flush priority and async reset.**
  - Flush with simultaneous ack and load -> level_o=0, IR unchanged, ir_valid_o=0.
  - Assert rst_n_i low mid-cycle -> outputs go to reset values without waiting for a clock edge.
